// File: rtl/nn_loop_sequencer_if.sv
// Bundle between the loop sequencer, its instruction memory and the downstream datapath.
// The master side is the sequencer; the slave side is whatever drives control and consumes ops.
interface nn_loop_sequencer_if #(
    parameter int INST_WIDTH     = 32,
    parameter int INST_MEM_DEPTH = 8,
    parameter int NU_COUNT       = 16,
    parameter int XY_MEM_DEPTH   = 10,
    parameter int W_MEM_DEPTH    = 12
) ();
    logic                      start;
    logic [INST_MEM_DEPTH-1:0] start_addr;
    logic                      stall;
    logic [INST_MEM_DEPTH-1:0] inst_addr;
    logic [INST_WIDTH-1:0]     inst_data;
    logic                      op_valid;
    logic [3:0]                op_code;
    logic [XY_MEM_DEPTH-1:0]   op_x_addr;
    logic [W_MEM_DEPTH-1:0]    op_w_addr;
    logic [NU_COUNT-1:0]       op_mac_sel;
    logic                      op_acc_loopback;
    logic [9:0]                op_length;
    logic                      busy;
    logic                      done;
    logic                      error;

    modport master (
        input  start, start_addr, stall, inst_data,
        output inst_addr, op_valid, op_code, op_x_addr, op_w_addr, op_mac_sel,
               op_acc_loopback, op_length, busy, done, error
    );

    modport slave (
        output start, start_addr, stall, inst_data,
        input  inst_addr, op_valid, op_code, op_x_addr, op_w_addr, op_mac_sel,
               op_acc_loopback, op_length, busy, done, error
    );
endinterface

// File: rtl/nn_loop_sequencer.sv
// Instruction sequencer for the MAC array: fetches one instruction per cycle, issues datapath ops,
// and runs hardware nested loops whose per-level strides offset the x/w addresses.
module nn_loop_sequencer #(
    parameter int INST_WIDTH     = 32,
    parameter int INST_MEM_DEPTH = 8,
    parameter int NU_COUNT       = 16,
    parameter int XY_MEM_DEPTH   = 10,
    parameter int W_MEM_DEPTH    = 12,
    parameter int LOOP_DEPTH     = 4
) (
    input logic              clk,
    input logic              reset_n,
    nn_loop_sequencer_if.master bus
);
    localparam int SP_W    = $clog2(LOOP_DEPTH + 1);
    localparam int IDX_W   = (LOOP_DEPTH > 1) ? $clog2(LOOP_DEPTH) : 1;
    localparam int STACK_N = 1 << IDX_W;

    localparam logic [3:0] OP_NOP     = 4'd0;
    localparam logic [3:0] OP_MATMUL  = 4'd1;
    localparam logic [3:0] OP_LOADMAC = 4'd2;
    localparam logic [3:0] OP_ACCMOV  = 4'd3;
    localparam logic [3:0] OP_LOOP    = 4'd4;
    localparam logic [3:0] OP_ENDLOOP = 4'd5;
    localparam logic [3:0] OP_JUMP    = 4'd6;
    localparam logic [3:0] OP_HALT    = 4'd15;

    typedef enum logic [1:0] {IDLE, RUN, DONE, ERROR} state_t;

    typedef struct packed {
        logic [INST_MEM_DEPTH-1:0] start_pc;
        logic [11:0]               count;
        logic [7:0]                x_stride;
        logic [7:0]                w_stride;
        logic [XY_MEM_DEPTH-1:0]   saved_x;
        logic [W_MEM_DEPTH-1:0]    saved_w;
    } loop_entry_t;

    state_t                    state_q, state_d;
    logic [INST_MEM_DEPTH-1:0] pc_q, pc_d;
    logic [SP_W-1:0]           sp_q, sp_d;
    loop_entry_t               stack_q [STACK_N];
    loop_entry_t               stack_d [STACK_N];
    logic [XY_MEM_DEPTH-1:0]   x_off_q, x_off_d;
    logic [W_MEM_DEPTH-1:0]    w_off_q, w_off_d;
    logic                      skip_q, skip_d;
    logic [7:0]                skip_depth_q, skip_depth_d;
    logic                      op_valid_q, op_valid_d;
    logic [3:0]                op_code_q, op_code_d;
    logic [XY_MEM_DEPTH-1:0]   op_x_addr_q, op_x_addr_d;
    logic [W_MEM_DEPTH-1:0]    op_w_addr_q, op_w_addr_d;
    logic [NU_COUNT-1:0]       op_mac_sel_q, op_mac_sel_d;
    logic                      op_acc_loopback_q, op_acc_loopback_d;
    logic [9:0]                op_length_q, op_length_d;
    logic                      done_q, done_d;
    logic                      error_q, error_d;

    logic [INST_WIDTH-1:0] inst;
    logic [3:0]            opcode;
    logic [5:0]            mac_idx;
    logic [11:0]           loop_count;
    logic [IDX_W-1:0]      top_idx;
    logic [IDX_W-1:0]      push_idx;
    loop_entry_t           top;

    assign inst       = bus.inst_data;
    assign opcode     = inst[31:28];
    assign mac_idx    = inst[27:22];
    assign loop_count = inst[27:16];
    assign top_idx    = IDX_W'(sp_q - 1'b1);
    assign push_idx   = IDX_W'(sp_q);
    assign top        = stack_q[top_idx];

    assign bus.inst_addr       = pc_q;
    assign bus.op_valid        = op_valid_q;
    assign bus.op_code         = op_code_q;
    assign bus.op_x_addr       = op_x_addr_q;
    assign bus.op_w_addr       = op_w_addr_q;
    assign bus.op_mac_sel      = op_mac_sel_q;
    assign bus.op_acc_loopback = op_acc_loopback_q;
    assign bus.op_length       = op_length_q;
    assign bus.busy            = (state_q == RUN);
    assign bus.done            = done_q;
    assign bus.error           = error_q;

    always_comb begin
        state_d           = state_q;
        pc_d              = pc_q;
        sp_d              = sp_q;
        stack_d           = stack_q;
        x_off_d           = x_off_q;
        w_off_d           = w_off_q;
        skip_d            = skip_q;
        skip_depth_d      = skip_depth_q;
        op_valid_d        = op_valid_q;
        op_code_d         = op_code_q;
        op_x_addr_d       = op_x_addr_q;
        op_w_addr_d       = op_w_addr_q;
        op_mac_sel_d      = op_mac_sel_q;
        op_acc_loopback_d = op_acc_loopback_q;
        op_length_d       = op_length_q;
        done_d            = 1'b0;
        error_d           = error_q;

        case (state_q)
            RUN: begin
                if (!bus.stall) begin
                    op_valid_d        = 1'b0;
                    op_code_d         = '0;
                    op_x_addr_d       = '0;
                    op_w_addr_d       = '0;
                    op_mac_sel_d      = '0;
                    op_acc_loopback_d = 1'b0;
                    op_length_d       = '0;
                    pc_d              = pc_q + 1'b1;

                    // A zero-count loop scans forward to its matching ENDLOOP without issuing.
                    if (skip_q) begin
                        if (opcode == OP_LOOP) begin
                            skip_depth_d = skip_depth_q + 1'b1;
                        end else if (opcode == OP_ENDLOOP) begin
                            if (skip_depth_q == 8'd0) skip_d = 1'b0;
                            else                      skip_depth_d = skip_depth_q - 1'b1;
                        end
                    end else begin
                        case (opcode)
                            OP_NOP: ;
                            OP_MATMUL: begin
                                op_valid_d        = 1'b1;
                                op_code_d         = opcode;
                                op_acc_loopback_d = inst[27];
                                op_x_addr_d       = XY_MEM_DEPTH'(inst[21:12]) + x_off_q;
                                op_w_addr_d       = W_MEM_DEPTH'(inst[11:0]) + w_off_q;
                            end
                            OP_LOADMAC: begin
                                if ({1'b0, mac_idx} >= 7'(NU_COUNT)) begin
                                    state_d = ERROR;
                                    error_d = 1'b1;
                                    pc_d    = pc_q;
                                end else begin
                                    op_valid_d   = 1'b1;
                                    op_code_d    = opcode;
                                    op_mac_sel_d = NU_COUNT'(1) << mac_idx;
                                    op_x_addr_d  = XY_MEM_DEPTH'(inst[9:0]) + x_off_q;
                                    op_w_addr_d  = w_off_q;
                                end
                            end
                            OP_ACCMOV: begin
                                op_valid_d  = 1'b1;
                                op_code_d   = opcode;
                                op_length_d = inst[19:10];
                                op_x_addr_d = XY_MEM_DEPTH'(inst[9:0]) + x_off_q;
                                op_w_addr_d = w_off_q;
                            end
                            OP_LOOP: begin
                                if (loop_count == 12'd0) begin
                                    skip_d       = 1'b1;
                                    skip_depth_d = 8'd0;
                                end else if (sp_q == SP_W'(LOOP_DEPTH)) begin
                                    state_d = ERROR;
                                    error_d = 1'b1;
                                    pc_d    = pc_q;
                                end else begin
                                    stack_d[push_idx].start_pc = pc_q + 1'b1;
                                    stack_d[push_idx].count    = loop_count;
                                    stack_d[push_idx].x_stride = inst[15:8];
                                    stack_d[push_idx].w_stride = inst[7:0];
                                    stack_d[push_idx].saved_x  = x_off_q;
                                    stack_d[push_idx].saved_w  = w_off_q;
                                    sp_d = sp_q + 1'b1;
                                end
                            end
                            OP_ENDLOOP: begin
                                if (sp_q == '0) begin
                                    state_d = ERROR;
                                    error_d = 1'b1;
                                    pc_d    = pc_q;
                                end else if (top.count > 12'd1) begin
                                    stack_d[top_idx].count = top.count - 1'b1;
                                    x_off_d = x_off_q + XY_MEM_DEPTH'(top.x_stride);
                                    w_off_d = w_off_q + W_MEM_DEPTH'(top.w_stride);
                                    pc_d    = top.start_pc;
                                end else begin
                                    x_off_d = top.saved_x;
                                    w_off_d = top.saved_w;
                                    sp_d    = sp_q - 1'b1;
                                end
                            end
                            OP_JUMP: pc_d = INST_MEM_DEPTH'(inst[7:0]);
                            OP_HALT: begin
                                state_d = DONE;
                                done_d  = 1'b1;
                                pc_d    = pc_q;
                            end
                            default: begin
                                state_d = ERROR;
                                error_d = 1'b1;
                                pc_d    = pc_q;
                            end
                        endcase
                    end
                end
            end
            default: begin
                if (bus.start) begin
                    state_d           = RUN;
                    pc_d              = bus.start_addr;
                    sp_d              = '0;
                    x_off_d           = '0;
                    w_off_d           = '0;
                    skip_d            = 1'b0;
                    skip_depth_d      = 8'd0;
                    error_d           = 1'b0;
                    op_valid_d        = 1'b0;
                    op_code_d         = '0;
                    op_x_addr_d       = '0;
                    op_w_addr_d       = '0;
                    op_mac_sel_d      = '0;
                    op_acc_loopback_d = 1'b0;
                    op_length_d       = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q           <= IDLE;
            pc_q              <= '0;
            sp_q              <= '0;
            for (int i = 0; i < STACK_N; i++) stack_q[i] <= '0;
            x_off_q           <= '0;
            w_off_q           <= '0;
            skip_q            <= 1'b0;
            skip_depth_q      <= 8'd0;
            op_valid_q        <= 1'b0;
            op_code_q         <= '0;
            op_x_addr_q       <= '0;
            op_w_addr_q       <= '0;
            op_mac_sel_q      <= '0;
            op_acc_loopback_q <= 1'b0;
            op_length_q       <= '0;
            done_q            <= 1'b0;
            error_q           <= 1'b0;
        end else begin
            state_q           <= state_d;
            pc_q              <= pc_d;
            sp_q              <= sp_d;
            stack_q           <= stack_d;
            x_off_q           <= x_off_d;
            w_off_q           <= w_off_d;
            skip_q            <= skip_d;
            skip_depth_q      <= skip_depth_d;
            op_valid_q        <= op_valid_d;
            op_code_q         <= op_code_d;
            op_x_addr_q       <= op_x_addr_d;
            op_w_addr_q       <= op_w_addr_d;
            op_mac_sel_q      <= op_mac_sel_d;
            op_acc_loopback_q <= op_acc_loopback_d;
            op_length_q       <= op_length_d;
            done_q            <= done_d;
            error_q           <= error_d;
        end
    end
endmodule

// File: doc/nn_loop_sequencer.md
Name: nn_loop_sequencer

Overview:
- Parametrised successor to the accelerator's instruction controller: fetches 32-bit instructions, issues MAC/serializer/mover operations one per cycle, and adds hardware nested loops (LOOP/ENDLOOP stack) with per-level x/w address strides.
- Also adds a start/busy/done handshake, a downstream stall, and error detection.
- Sits between instruction memory and the MAC array / XY / W memories.
- Instruction memory reads combinationally: inst_data corresponds to inst_addr in the same cycle.

Parameters:
- INST_WIDTH, 32, instruction word width (field map below is fixed for 32).
- INST_MEM_DEPTH, 8, instruction address width.
- NU_COUNT, 16, number of MAC units; 2..64.
- XY_MEM_DEPTH, 10, XY address width.
- W_MEM_DEPTH, 12, W address width.
- LOOP_DEPTH, 4, loop stack entries; 1..8.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; begins execution at start_addr when IDLE/DONE/ERROR
- start_addr  in  INST_MEM_DEPTH  first instruction address
- stall  in  1  downstream not ready; freezes the sequencer
- inst_addr  out  INST_MEM_DEPTH  instruction fetch address
- inst_data  in  INST_WIDTH  instruction at inst_addr
- op_valid  out  1  registered; an operation is issued this cycle
- op_code  out  4  opcode of the issued operation
- op_x_addr  out  XY_MEM_DEPTH  base x/y address + x offset
- op_w_addr  out  W_MEM_DEPTH  base w address + w offset
- op_mac_sel  out  NU_COUNT  one-hot MAC register enable (LOADMAC only, else 0)
- op_acc_loopback  out  1  MATMUL accumulate bit
- op_length  out  10  ACCMOV length
- busy  out  1  state is RUN
- done  out  1  one-cycle pulse on HALT
- error  out  1  sticky until start or reset

Behaviour:
- Field map:
  - opcode [31:28]; NOP=0, MATMUL=1, LOADMAC=2, ACCMOV=3, LOOP=4, ENDLOOP=5, JUMP=6, HALT=15; all others are illegal.
  - MATMUL: [27] loopback, [21:12] x, [11:0] w.
  - LOADMAC: [27:22] mac index, [9:0] x.
  - ACCMOV: [19:10] length, [9:0] y.
  - LOOP: [27:16] count, [15:8] x_stride, [7:0] w_stride.
  - JUMP: [7:0] target.
- States: IDLE, RUN, DONE, ERROR.
- Reset (reset_n=0 at posedge):
  - state=IDLE; inst_addr=0; stack empty; x_off=w_off=0.
  - All op_* = 0; busy=done=error=0.
- start in IDLE/DONE/ERROR:
  - inst_addr<=start_addr; clear stack, offsets and error; state<=RUN.
  - start in RUN is ignored.
- In RUN with stall=1: pc, stack, offsets and all op_* outputs hold (op_valid holds its value).
- In RUN with stall=0: decode inst_data; outputs are registered, so an op appears one cycle after its fetch address.
  - MATMUL/LOADMAC/ACCMOV: op_valid<=1; addresses get offsets added, truncated modulo 2^width; pc+1.
  - LOADMAC: mac index >= NU_COUNT -> ERROR.
  - NOP: op_valid<=0; pc+1.
  - JUMP: op_valid<=0; pc<=target.
  - LOOP:
    - count=0: skip forward; scan pc+1 onward for the matching ENDLOOP, one instruction per cycle, tracking nesting, no issue; continue after it.
    - count>=1: push {pc+1, count, x_stride, w_stride, saved x_off, saved w_off}; pc+1.
    - Push when the stack is full -> ERROR.
  - ENDLOOP:
    - Stack empty -> ERROR.
    - Top count>1: decrement count; x_off+=x_stride; w_off+=w_stride; pc<=top start.
    - Top count==1: restore saved offsets, pop, pc+1.
    - A LOOP with count=1 therefore runs its body once with unchanged offsets.
  - HALT: op_valid<=0; done pulses 1 cycle; state<=DONE; pc holds.
  - Illegal opcode -> ERROR.
- ERROR: op_valid<=0, error=1, busy=0; all state is frozen until start or reset.
- pc increments wrap modulo 2^INST_MEM_DEPTH.
- Loop and offset arithmetic is unsigned; offsets wrap.
- ENDLOOP and LOOP each cost one cycle with op_valid=0.
- Reset mid-run overrides everything, including stall and start.

Test Plan:
- Straight line: program MATMUL(x=5, w=7, lb=0), HALT; start_addr=0 -> op_valid one cycle with x=5, w=7; next cycle done=1; busy falls.
- Strided loop: LOOP(count=3, xs=2, ws=16), MATMUL(x=10, w=100), ENDLOOP, HALT -> MATMUL issued 3 times with (x,w)=(10,100),(12,116),(14,132); offsets back to 0 after the loop.
- Nested: outer LOOP(2, xs=1), inner LOOP(2, xs=4), MATMUL(x=0), 2xENDLOOP -> x sequence 0, 4, 1, 5.
- Stall: assert stall for 3 cycles during the second iteration -> outputs frozen, no skipped or duplicated ops, total issue count 3.
- Errors: LOOP_DEPTH+1 nested LOOPs -> error=1 at the overflowing push. Separately, ENDLOOP with an empty stack -> error. LOADMAC idx=NU_COUNT -> error. A subsequent start clears error and runs.
- Reset mid-loop: deassert reset_n during the inner loop -> all outputs 0 next cycle, state IDLE; restart reproduces the full sequence from the beginning.
